// File: rtl/ltl_mon_pkg.sv
// Shared types for the LTL monitor symbol path: symbol width/type and the
// streamer state encoding, plus the predicate-to-symbol packing rule.
package ltl_mon_pkg;

    localparam int SYM_W = 8;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARST,
        ST_STREAM,
        ST_DRAIN
    } stream_state_e;

    // Monitor alphabets are 7 bits wide; the MSB of every symbol is reserved as zero.
    function automatic sym_t pred_to_sym(input logic [6:0] pred);
        return {1'b0, pred};
    endfunction

endpackage

// File: rtl/ltl_symbol_streamer_if.sv
// Event handshake from the predicate extractor plus the symbol/run/reset
// lines fanned out to the monitor clusters.
interface ltl_symbol_streamer_if #(
    parameter int PRED_W = 7
);
    import ltl_mon_pkg::*;

    logic              ev_valid;
    logic              ev_ready;
    logic [PRED_W-1:0] ev_pred;
    sym_t              symbols;
    logic              run;
    logic              am_reset;

    // master is the event producer / symbol consumer, slave is the streamer itself
    modport master (
        output ev_valid,
        output ev_pred,
        input  ev_ready,
        input  symbols,
        input  run,
        input  am_reset
    );

    modport slave (
        input  ev_valid,
        input  ev_pred,
        output ev_ready,
        output symbols,
        output run,
        output am_reset
    );

endinterface

// File: rtl/ltl_sym_fifo.sv
// Small synchronous symbol FIFO with flush; full/empty come straight from the
// registered occupancy count so they are stable for the whole cycle.
module ltl_sym_fifo
    import ltl_mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic push,
    input  sym_t wdata,
    input  logic pop,
    output sym_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    sym_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ltl_symbol_streamer.sv
// Packs commit-stage predicate events into monitor symbols, buffers them, and
// frames each trace with an automata reset pulse before streaming.
module ltl_symbol_streamer
    import ltl_mon_pkg::*;
#(
    parameter int PRED_W     = 7,
    parameter int FIFO_DEPTH = 8,
    parameter int RST_CYCLES = 2,
    parameter int DEDUP      = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trace_start,
    input  logic                  trace_stop,
    ltl_symbol_streamer_if.slave  bus,
    output logic                  busy,
    output logic [15:0]           overflow_cnt
);

    localparam int CNT_W = $clog2(RST_CYCLES) + 1;

    stream_state_e state;
    logic [CNT_W-1:0] rst_cnt;
    sym_t  sym_in;
    sym_t  last_sym;
    logic  last_ok;
    sym_t  fifo_head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_flush;
    logic  accept;
    logic  dup;
    logic  write;
    logic  issue;

    assign sym_in     = pred_to_sym(bus.ev_pred[6:0]);
    assign bus.ev_ready = (state == ST_STREAM) && !fifo_full;
    assign busy       = (state != ST_IDLE);
    assign accept     = bus.ev_valid && bus.ev_ready;
    assign dup        = (DEDUP != 0) && last_ok && (sym_in == last_sym);
    assign write      = accept && !dup;
    assign fifo_flush = trace_start || (state == ST_ARST);
    // A restart discards whatever is queued, so nothing is issued on that edge.
    assign issue      = ((state == ST_STREAM) || (state == ST_DRAIN)) && !fifo_empty && !trace_start;

    ltl_sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (fifo_flush),
        .push    (write),
        .wdata   (sym_in),
        .pop     (issue),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Trace framing FSM with registered symbol/run/am_reset outputs and dedup history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rst_cnt      <= '0;
            bus.am_reset <= 1'b1;
            bus.run      <= 1'b0;
            bus.symbols  <= '0;
            last_sym     <= '0;
            last_ok      <= 1'b0;
        end else begin
            bus.run <= issue;
            if (issue) bus.symbols <= fifo_head;
            if (write) begin
                last_sym <= sym_in;
                last_ok  <= 1'b1;
            end
            if (trace_start) begin
                state        <= ST_ARST;
                rst_cnt      <= '0;
                bus.am_reset <= 1'b1;
                last_ok      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_ARST: begin
                        last_ok <= 1'b0;
                        // Leaving ARST with an empty FIFO guarantees a full idle cycle before the first run.
                        if (rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                            state        <= ST_STREAM;
                            bus.am_reset <= 1'b0;
                        end else begin
                            rst_cnt <= rst_cnt + CNT_W'(1);
                        end
                    end
                    ST_STREAM: if (trace_stop) state <= ST_DRAIN;
                    ST_DRAIN: begin
                        if (fifo_empty) begin
                            state        <= ST_IDLE;
                            bus.am_reset <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Dropped-event counter survives trace restarts; only reset_n clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_cnt <= '0;
        end else if ((state == ST_STREAM) && bus.ev_valid && !bus.ev_ready
                     && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ltl_symbol_streamer.sv
// Self-checking bench: directed trace scenarios plus randomized traffic checked
// cycle by cycle against a queue-based reference model of the streamer.
module tb_ltl_symbol_streamer;
    import ltl_mon_pkg::*;

    localparam int DEPTH = 2;
    localparam int RSTC  = 2;
    localparam int DEDUP = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trace_start = 1'b0;
    logic        trace_stop = 1'b0;
    logic        busy;
    logic [15:0] overflow_cnt;

    ltl_symbol_streamer_if #(.PRED_W(7)) bus ();

    ltl_symbol_streamer #(
        .PRED_W     (7),
        .FIFO_DEPTH (DEPTH),
        .RST_CYCLES (RSTC),
        .DEDUP      (DEDUP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_start  (trace_start),
        .trace_stop   (trace_stop),
        .bus          (bus.slave),
        .busy         (busy),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: phase 0 idle, 1 automata reset, 2 streaming, 3 draining.
    int         m_phase;
    int         m_rcnt;
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    bit         m_last_ok;
    logic [7:0] m_sym;
    bit         m_run;
    int         m_ovf;
    logic [7:0] issued[$];

    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task modelReset();
        m_phase = 0;
        m_rcnt = 0;
        m_q.delete();
        m_last = 8'h00;
        m_last_ok = 0;
        m_sym = 8'h00;
        m_run = 0;
        m_ovf = 0;
    endtask

    function bit expReady();
        return (m_phase == 2) && (m_q.size() < DEPTH);
    endfunction

    task modelStep(input bit ts, input bit tp, input bit v, input logic [6:0] p);
        bit rdy;
        int sz;
        logic [7:0] s;
        rdy = expReady();
        sz  = m_q.size();
        s   = {1'b0, p};
        if (m_phase == 2 && v && !rdy && m_ovf < 65535) m_ovf++;
        m_run = (m_phase >= 2) && (sz > 0) && !ts;
        if (m_run) m_sym = m_q.pop_front();
        if (v && rdy && !(DEDUP != 0 && m_last_ok && s == m_last)) begin
            m_q.push_back(s);
            m_last = s;
            m_last_ok = 1;
        end
        if (ts) begin
            m_phase = 1;
            m_rcnt = 0;
            m_q.delete();
            m_last_ok = 0;
        end else begin
            case (m_phase)
                1: begin
                    m_q.delete();
                    m_last_ok = 0;
                    if (m_rcnt == RSTC - 1) m_phase = 2;
                    else m_rcnt++;
                end
                2: if (tp) m_phase = 3;
                3: if (sz == 0) m_phase = 0;
                default: ;
            endcase
        end
    endtask

    task compareAll();
        checkOutput("am_reset", bus.am_reset, (m_phase <= 1));
        checkOutput("busy", busy, (m_phase != 0));
        checkOutput("ev_ready", bus.ev_ready, expReady());
        checkOutput("run", bus.run, m_run);
        checkOutput("symbols", bus.symbols, m_sym);
        checkOutput("overflow_cnt", overflow_cnt, m_ovf);
        if (bus.run === 1'b1) begin
            issued.push_back(bus.symbols);
            checkOutput("sym_bit7", bus.symbols[7], 1'b0);
        end
    endtask

    task applyStimulus(input bit ts, input bit tp, input bit v, input logic [6:0] p);
        trace_start  = ts;
        trace_stop   = tp;
        bus.ev_valid = v;
        bus.ev_pred  = p;
        @(posedge clk);
        modelStep(ts, tp, v, p);
        @(negedge clk);
        compareAll();
    endtask

    task idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 7'h00);
    endtask

    initial begin
        int ar;
        logic [7:0] exp_a[3];
        bit ts, tp, v;
        logic [6:0] p;

        modelReset();
        bus.ev_valid = 1'b0;
        bus.ev_pred  = 7'h00;
        #12;
        compareAll();
        @(negedge clk);
        reset_n = 1'b1;
        idleCycles(2);

        // Trace start: reset pulse length and first STREAM cycle
        applyStimulus(1, 0, 0, 7'h00);
        ar = bus.am_reset ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 7'h00);
            if (bus.am_reset) ar++;
        end
        checkOutput("arst_len", ar, RSTC);

        // Back-to-back distinct events
        issued.delete();
        applyStimulus(0, 0, 1, 7'h05);
        applyStimulus(0, 0, 1, 7'h11);
        applyStimulus(0, 0, 1, 7'h7F);
        idleCycles(4);
        exp_a = '{8'h05, 8'h11, 8'h7F};
        checkOutput("seq_len", issued.size(), 3);
        for (int i = 0; i < 3 && i < issued.size(); i++) checkOutput("seq_val", issued[i], exp_a[i]);

        // Duplicate suppression, and history cleared by a new trace
        issued.delete();
        applyStimulus(0, 0, 1, 7'h20);
        applyStimulus(0, 0, 1, 7'h20);
        applyStimulus(0, 0, 1, 7'h21);
        idleCycles(3);
        checkOutput("dedup_len", issued.size(), 2);
        if (issued.size() == 2) begin
            checkOutput("dedup_0", issued[0], 8'h20);
            checkOutput("dedup_1", issued[1], 8'h21);
        end
        applyStimulus(1, 0, 0, 7'h00);
        idleCycles(3);
        issued.delete();
        applyStimulus(0, 0, 1, 7'h20);
        idleCycles(3);
        checkOutput("restart_len", issued.size(), 1);
        if (issued.size() == 1) checkOutput("restart_sym", issued[0], 8'h20);

        // Stop with traffic in flight: everything drains, then idle
        issued.delete();
        applyStimulus(0, 0, 1, 7'h31);
        applyStimulus(0, 0, 1, 7'h32);
        applyStimulus(0, 1, 1, 7'h33);
        idleCycles(4);
        checkOutput("drain_len", issued.size(), 3);
        checkOutput("drain_busy", busy, 1'b0);
        checkOutput("drain_am_reset", bus.am_reset, 1'b1);

        // Asynchronous reset while draining
        applyStimulus(1, 0, 0, 7'h00);
        idleCycles(3);
        applyStimulus(0, 0, 1, 7'h41);
        applyStimulus(0, 1, 1, 7'h42);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_run", bus.run, 1'b0);
        checkOutput("async_am_reset", bus.am_reset, 1'b1);
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_ready", bus.ev_ready, 1'b0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        compareAll();
        issued.delete();
        applyStimulus(1, 0, 0, 7'h00);
        idleCycles(6);
        checkOutput("post_reset_empty", issued.size(), 0);

        // Randomized traffic with occasional restarts and stops
        applyStimulus(1, 0, 0, 7'h00);
        for (int i = 0; i < 600; i++) begin
            ts = ($urandom_range(0, 99) < 2);
            tp = ($urandom_range(0, 99) < 4);
            v  = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 1) == 1) p = 7'($urandom_range(0, 3));
            else p = 7'($urandom);
            applyStimulus(ts, tp, v, p);
        end
        idleCycles(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
